// File: rtl/fg_prog_pkg.sv
// Shared types and constants for the floating-gate programming sequencer.
// States, mode encoding, default phase timing and the phase-timer width.
package fg_prog_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_GAP,
      ST_RELEASE
   } state_e;

   localparam logic MODE_INJ = 1'b0;
   localparam logic MODE_TUN = 1'b1;

   localparam int DEF_NUM_ROWS  = 10;
   localparam int DEF_ROW_BITS  = 6;
   localparam int DEF_COL_BITS  = 5;
   localparam int DEF_SETUP_CYC = 4;
   localparam int DEF_PULSE_CYC = 100;
   localparam int DEF_GAP_CYC   = 20;

   // Wide enough for any practical phase length; a phase of L cycles loads L-1.
   localparam int TIMER_W = 16;

endpackage

// File: rtl/fg_prog_timer.sv
// Loadable down-counter with terminal-count flag, shared by the SETUP, PULSE
// and GAP phases of the sequencer.
module fg_prog_timer
   import fg_prog_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: decoder setup, N inject/tunnel pulses
// separated by gaps, then release. Optional abort input under FG_PROG_ABORT_EN.
module fg_prog_sequencer
   import fg_prog_pkg::*;
#(
   parameter int NUM_ROWS  = DEF_NUM_ROWS,
   parameter int ROW_BITS  = DEF_ROW_BITS,
   parameter int COL_BITS  = DEF_COL_BITS,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int PULSE_CYC = DEF_PULSE_CYC,
   parameter int GAP_CYC   = DEF_GAP_CYC
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ROW_BITS-1:0] cmd_row,
   input  logic [COL_BITS-1:0] cmd_col,
   input  logic                cmd_mode,
   input  logic [7:0]          cmd_pulses,
   output logic [ROW_BITS-1:0] dec_row,
   output logic [COL_BITS-1:0] dec_col,
   output logic                dec_en,
   output logic                drain_sel,
   output logic                prog_en,
   output logic                vinj_pulse,
   output logic                tun_en,
   output logic                busy,
   output logic                done,
   output logic                err
`ifdef FG_PROG_ABORT_EN
   ,
   input  logic                abort
`endif
);

   localparam logic [TIMER_W-1:0] SETUP_LD = TIMER_W'(SETUP_CYC - 1);
   localparam logic [TIMER_W-1:0] PULSE_LD = TIMER_W'(PULSE_CYC - 1);
   localparam logic [TIMER_W-1:0] GAP_LD   = TIMER_W'(GAP_CYC - 1);

   state_e              state_q, state_d;
   logic [ROW_BITS-1:0] row_q, row_d;
   logic [COL_BITS-1:0] col_q, col_d;
   logic                mode_q, mode_d;
   logic [7:0]          pulses_q, pulses_d;
   logic                err_q, err_d;

   logic                tmr_load;
   logic [TIMER_W-1:0]  tmr_val;
   logic                tmr_tc;
   logic                row_ok;

   assign row_ok = (32'(cmd_row) < 32'(NUM_ROWS));

   fg_prog_timer #(.W(TIMER_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .tc_o       (tmr_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         row_q    <= '0;
         col_q    <= '0;
         mode_q   <= MODE_INJ;
         pulses_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         mode_q   <= mode_d;
         pulses_q <= pulses_d;
         err_q    <= err_d;
      end
   end

   // Drives decode straight from state_q so an async reset drops them at once.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      mode_d     = mode_q;
      pulses_d   = pulses_q;
      err_d      = err_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      cmd_ready  = 1'b0;
      dec_en     = 1'b0;
      drain_sel  = 1'b0;
      prog_en    = 1'b0;
      vinj_pulse = 1'b0;
      tun_en     = 1'b0;
      done       = 1'b0;
      err        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               row_d    = cmd_row;
               col_d    = cmd_col;
               mode_d   = cmd_mode;
               pulses_d = cmd_pulses;
               err_d    = !row_ok;
               if (row_ok) begin
                  state_d  = ST_SETUP;
                  tmr_load = 1'b1;
                  tmr_val  = SETUP_LD;
               end else begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_SETUP: begin
            dec_en    = 1'b1;
            prog_en   = 1'b1;
            drain_sel = (mode_q == MODE_INJ);
            if (tmr_tc) begin
               if (pulses_q != 8'd0) begin
                  state_d  = ST_PULSE;
                  tmr_load = 1'b1;
                  tmr_val  = PULSE_LD;
               end else begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_PULSE: begin
            dec_en     = 1'b1;
            prog_en    = 1'b1;
            drain_sel  = (mode_q == MODE_INJ);
            vinj_pulse = (mode_q == MODE_INJ);
            tun_en     = (mode_q == MODE_TUN);
            if (tmr_tc) begin
               pulses_d = pulses_q - 8'd1;
               if (pulses_q != 8'd1) begin
                  state_d  = ST_GAP;
                  tmr_load = 1'b1;
                  tmr_val  = GAP_LD;
               end else begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_GAP: begin
            dec_en    = 1'b1;
            prog_en   = 1'b1;
            drain_sel = (mode_q == MODE_INJ);
            if (tmr_tc) begin
               state_d  = ST_PULSE;
               tmr_load = 1'b1;
               tmr_val  = PULSE_LD;
            end
         end
         ST_RELEASE: begin
            done    = 1'b1;
            err     = err_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef FG_PROG_ABORT_EN
      if (abort && (state_q == ST_SETUP || state_q == ST_PULSE || state_q == ST_GAP)) begin
         state_d  = ST_RELEASE;
         tmr_load = 1'b0;
      end
`endif
   end

   assign dec_row = row_q;
   assign dec_col = col_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Bench for fg_prog_sequencer: a timeline model predicts every output from the
// cycles elapsed since accept; directed commands pin the model with literal latencies.
module tb_fg_prog_sequencer;
   import fg_prog_pkg::*;

   localparam int NR = 10;
   localparam int RB = 6;
   localparam int CB = 5;
   localparam int S  = 4;
   localparam int P  = 100;
   localparam int G  = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [RB-1:0] cmd_row = '0;
   logic [CB-1:0] cmd_col = '0;
   logic          cmd_mode = 1'b0;
   logic [7:0]    cmd_pulses = '0;
   logic [RB-1:0] dec_row;
   logic [CB-1:0] dec_col;
   logic          dec_en, drain_sel, prog_en, vinj_pulse, tun_en, busy, done, err;
`ifdef FG_PROG_ABORT_EN
   logic          abort = 1'b0;
`endif

   fg_prog_sequencer #(
      .NUM_ROWS(NR), .ROW_BITS(RB), .COL_BITS(CB),
      .SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_mode(cmd_mode), .cmd_pulses(cmd_pulses),
      .dec_row(dec_row), .dec_col(dec_col), .dec_en(dec_en), .drain_sel(drain_sel),
      .prog_en(prog_en), .vinj_pulse(vinj_pulse), .tun_en(tun_en),
      .busy(busy), .done(done), .err(err)
`ifdef FG_PROG_ABORT_EN
      , .abort(abort)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
      end
   endtask

   // Model: while a command is active, m_k counts cycles since its accept edge
   // and m_total is the cycle on which done must appear.
   bit m_active = 1'b0;
   int m_k = 0, m_total = 0;
   bit m_mode = 1'b0, m_bad = 1'b0;
   int m_row = 0, m_col = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_k = 0;
         m_row = 0;
         m_col = 0;
      end else if (m_active) begin
`ifdef FG_PROG_ABORT_EN
         if (abort && !m_bad && m_k < m_total) m_total = m_k + 1;
`endif
         if (m_k == m_total) m_active = 1'b0;
         else m_k++;
      end else if (cmd_valid) begin
         int n;
         n = int'(cmd_pulses);
         m_row = int'(cmd_row);
         m_col = int'(cmd_col);
         m_mode = cmd_mode;
         m_bad = (int'(cmd_row) >= NR);
         m_total = m_bad ? 1 : 1 + S + n * P + ((n > 0) ? n - 1 : 0) * G;
         m_k = 1;
         m_active = 1'b1;
      end
   end

   always @(negedge clk) begin
      int e_ready, e_busy, e_en, e_drain, e_vinj, e_tun, e_done, e_err, j;
      e_ready = 0; e_busy = 0; e_en = 0; e_drain = 0;
      e_vinj = 0; e_tun = 0; e_done = 0; e_err = 0;
      if (!m_active) begin
         e_ready = 1;
      end else begin
         e_busy = 1;
         if (m_k == m_total) begin
            e_done = 1;
            e_err = int'(m_bad);
         end else begin
            e_en = 1;
            e_drain = int'(!m_mode);
            j = m_k - 1 - S;
            if (j >= 0 && (j % (P + G)) < P) begin
               e_vinj = int'(!m_mode);
               e_tun = int'(m_mode);
            end
         end
      end
      check("cmd_ready", int'(cmd_ready), e_ready);
      check("busy", int'(busy), e_busy);
      check("dec_en", int'(dec_en), e_en);
      check("prog_en", int'(prog_en), e_en);
      check("drain_sel", int'(drain_sel), e_drain);
      check("vinj_pulse", int'(vinj_pulse), e_vinj);
      check("tun_en", int'(tun_en), e_tun);
      check("done", int'(done), e_done);
      check("err", int'(err), e_err);
      check("dec_row", int'(dec_row), m_row);
      check("dec_col", int'(dec_col), m_col);
      check("pulse_exclusive", int'(vinj_pulse & tun_en), 0);
   end

   task automatic wait_ready();
      int b;
      b = 0;
      @(negedge clk);
      while (!cmd_ready && b < 2000) begin
         @(negedge clk);
         b++;
      end
      check("wait_ready_budget", int'(cmd_ready), 1);
   endtask

   // Offer one command at a negedge; it is accepted on the next posedge.
   task automatic issue(input int row, input int col, input int mode, input int pulses);
      cmd_valid = 1'b1;
      cmd_row = RB'(row);
      cmd_col = CB'(col);
      cmd_mode = mode[0];
      cmd_pulses = 8'(pulses);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input int row, input int col, input int mode, input int pulses,
                          output int lat, output int n_vinj, output int n_tun,
                          output int n_drain, output int n_en, output int err_seen);
      wait_ready();
      issue(row, col, mode, pulses);
      lat = -1; n_vinj = 0; n_tun = 0; n_drain = 0; n_en = 0; err_seen = -1;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         n_vinj += int'(vinj_pulse);
         n_tun += int'(tun_en);
         n_drain += int'(drain_sel);
         n_en += int'(dec_en);
         if (done) begin
            lat = k;
            err_seen = int'(err);
            break;
         end
      end
   endtask

   initial begin
      int lat, nv, nt, nd, ne, es, dcount;

      #2;
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_dec_en", int'(dec_en), 0);
      check("rst_dec_row", int'(dec_row), 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // Inject, row 3, col 7, two pulses.
      run_cmd(3, 7, 0, 2, lat, nv, nt, nd, ne, es);
      check("inj2_latency", lat, 225);
      check("inj2_vinj_cycles", nv, 200);
      check("inj2_tun_cycles", nt, 0);
      check("inj2_drain_cycles", nd, 224);
      check("inj2_en_cycles", ne, 224);
      check("inj2_err", es, 0);

      // Back-to-back: accepted in the IDLE cycle right after RELEASE.
      run_cmd(5, 2, 1, 1, lat, nv, nt, nd, ne, es);
      check("tun1_latency", lat, 105);
      check("tun1_tun_cycles", nt, 100);
      check("tun1_vinj_cycles", nv, 0);
      check("tun1_drain_cycles", nd, 0);
      check("tun1_en_cycles", ne, 104);

      run_cmd(9, 31, 0, 0, lat, nv, nt, nd, ne, es);
      check("zero_latency", lat, 5);
      check("zero_pulse_cycles", nv + nt, 0);
      check("zero_en_cycles", ne, 4);

      run_cmd(10, 4, 0, 3, lat, nv, nt, nd, ne, es);
      check("badrow_latency", lat, 1);
      check("badrow_err", es, 1);
      check("badrow_en_cycles", ne, 0);
      @(negedge clk);
      check("idle_holds_row", int'(dec_row), 10);
      check("idle_holds_col", int'(dec_col), 4);

      // Reset during the second pulse of a three-pulse inject.
      wait_ready();
      issue(2, 1, 0, 3);
      repeat (149) @(posedge clk);
      #1 check("vinj_before_reset", int'(vinj_pulse), 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_vinj", int'(vinj_pulse), 0);
      check("async_rst_dec_en", int'(dec_en), 0);
      check("async_rst_prog_en", int'(prog_en), 0);
      check("async_rst_drain", int'(drain_sel), 0);
      check("async_rst_ready", int'(cmd_ready), 1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      dcount = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         dcount += int'(done);
      end
      check("no_done_after_reset", dcount, 0);
      check("ready_after_reset", int'(cmd_ready), 1);

`ifdef FG_PROG_ABORT_EN
      wait_ready();
      issue(4, 6, 0, 2);
      lat = -1;
      es = -1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         abort = (k == 54);
         if (done) begin
            lat = k;
            es = int'(err);
            break;
         end
      end
      abort = 1'b0;
      check("abort_latency", lat, 55);
      check("abort_err", es, 0);
      run_cmd(1, 1, 1, 0, lat, nv, nt, nd, ne, es);
      check("after_abort_latency", lat, 5);
`endif

      // Random stream; the model follows every accept.
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_row = RB'($urandom_range(0, 12));
         cmd_col = CB'($urandom);
         cmd_mode = 1'($urandom);
         cmd_pulses = 8'($urandom_range(0, 2));
      end
      cmd_valid = 1'b0;
      wait_ready();
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
